// File: rtl/regbank_pkg.sv
// Shared constants and requester identifiers for the register-bank writeback arbiter.
package regbank_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  // Scoreboard only tracks addresses that map onto one of its NREG bits.
  function automatic logic inRange(input logic [ADDR_W-1:0] addr);
    return int'(addr) < NREG;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational, the pointer
// moves to the non-granted requester after every grant.
module rr_arb2
  import regbank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic aluValid,
  input  logic memValid,
  output logic aluGrant,
  output logic memGrant
);

  req_id_e ptr;

  always_comb begin
    aluGrant = 1'b0;
    memGrant = 1'b0;
    if (rst_n) begin
      if (aluValid && (!memValid || ptr == REQ_ALU)) aluGrant = 1'b1;
      else if (memValid)                             memGrant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        ptr <= REQ_ALU;
    else if (aluGrant) ptr <= REQ_MEM;
    else if (memGrant) ptr <= REQ_ALU;
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard for the register bank's single write port.
// Optional WBARB_FWD_EN adds bypass hit flags that mask busy for the register being written now.
module regbank_wb_arbiter
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] chk_a,
  input  logic [ADDR_W-1:0] chk_b,
  output logic              busy_a,
  output logic              busy_b,
`ifdef WBARB_FWD_EN
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              rf_w,
  output logic [ADDR_W-1:0] rf_c,
  output logic [DATA_W-1:0] rf_dataC
);

  logic            aluHs;
  logic            memHs;
  logic [NREG-1:0] pendBits;
  logic [NREG-1:0] pendNext;
  logic            sbA;
  logic            sbB;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .aluValid (alu_valid),
    .memValid (mem_valid),
    .aluGrant (alu_ready),
    .memGrant (mem_ready)
  );

  assign aluHs = alu_valid & alu_ready;
  assign memHs = mem_valid & mem_ready;

  // Stage p1: registered write port, one cycle after the handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_w     <= 1'b0;
      rf_c     <= '0;
      rf_dataC <= '0;
    end else if (aluHs) begin
      rf_w     <= (alu_addr != ZERO_REG);
      rf_c     <= alu_addr;
      rf_dataC <= alu_data;
    end else if (memHs) begin
      rf_w     <= (mem_addr != ZERO_REG);
      rf_c     <= mem_addr;
      rf_dataC <= mem_data;
    end else begin
      rf_w     <= 1'b0;
    end
  end

  // A claim landing on the register being retired wins: it marks a new producer.
  always_comb begin
    pendNext = pendBits;
    if (rf_w && inRange(rf_c))
      pendNext[rf_c] = 1'b0;
    if (claim_valid && claim_addr != ZERO_REG && inRange(claim_addr))
      pendNext[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pendBits <= '0;
    else        pendBits <= pendNext;
  end

  assign sbA = inRange(chk_a) && chk_a != ZERO_REG && pendBits[chk_a];
  assign sbB = inRange(chk_b) && chk_b != ZERO_REG && pendBits[chk_b];

`ifdef WBARB_FWD_EN
  assign fwd_a_hit = rf_w && rf_c == chk_a && !(claim_valid && claim_addr == chk_a);
  assign fwd_b_hit = rf_w && rf_c == chk_b && !(claim_valid && claim_addr == chk_b);
  assign fwd_data  = rf_dataC;
  assign busy_a    = sbA & ~fwd_a_hit;
  assign busy_b    = sbB & ~fwd_b_hit;
`else
  assign busy_a    = sbA;
  assign busy_b    = sbB;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed plus constrained-random bench for regbank_wb_arbiter with an expected-write queue.
module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, claim_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, claim_addr, chk_a, chk_b;
  logic [63:0] alu_data, mem_data;
  logic        busy_a, busy_b;
  logic        rf_w;
  logic [4:0]  rf_c;
  logic [63:0] rf_dataC;
`ifdef WBARB_FWD_EN
  logic        fwd_a_hit, fwd_b_hit;
  logic [63:0] fwd_data;
`endif

  always #5 clk = ~clk;

  regbank_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .chk_a       (chk_a),
    .chk_b       (chk_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
`ifdef WBARB_FWD_EN
    .fwd_a_hit   (fwd_a_hit),
    .fwd_b_hit   (fwd_b_hit),
    .fwd_data    (fwd_data),
`endif
    .rf_w        (rf_w),
    .rf_c        (rf_c),
    .rf_dataC    (rf_dataC)
  );

  typedef struct packed {
    logic        w;
    logic [4:0]  c;
    logic [63:0] d;
    logic        full;
  } rf_exp_t;

  rf_exp_t     expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit   [31:0] mSb = '0;
  bit          mPtr = 1'b0;
  bit          mW = 1'b0;
  logic [4:0]  mC = '0;
  logic [63:0] mD = '0;
  bit          expAluRdy, expMemRdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic expBusy(input logic [4:0] a);
    logic b;
    b = (a != 5'd31) && mSb[a];
`ifdef WBARB_FWD_EN
    if (mW && mC == a && !(claim_valid && claim_addr == a)) b = 1'b0;
`endif
    return b;
  endfunction

  // Called just after a negedge with inputs already driven; advances one clock.
  task automatic cycle(input bit lateRst = 1'b0);
    rf_exp_t e;
    bit aHs, mHs;
    #1;
    expAluRdy = rst_n && alu_valid && (!mem_valid || mPtr == 1'b0);
    expMemRdy = rst_n && mem_valid && !expAluRdy;
    chk("alu_ready", 64'(alu_ready), 64'(expAluRdy));
    chk("mem_ready", 64'(mem_ready), 64'(expMemRdy));
    chk("busy_a", 64'(busy_a), 64'(expBusy(chk_a)));
    chk("busy_b", 64'(busy_b), 64'(expBusy(chk_b)));
    aHs = expAluRdy;
    mHs = expMemRdy;
    if (lateRst) rst_n = 1'b0;
    if (!rst_n)   e = '{w: 1'b0, c: 5'd0, d: 64'd0, full: 1'b1};
    else if (aHs) e = '{w: (alu_addr != 5'd31), c: alu_addr, d: alu_data, full: 1'b0};
    else if (mHs) e = '{w: (mem_addr != 5'd31), c: mem_addr, d: mem_data, full: 1'b0};
    else          e = '{w: 1'b0, c: mC, d: mD, full: 1'b0};
    expQ.push_back(e);
    if (!rst_n) begin
      mSb  = '0;
      mPtr = 1'b0;
    end else begin
      if (mW) mSb[mC] = 1'b0;
      if (claim_valid && claim_addr != 5'd31) mSb[claim_addr] = 1'b1;
      if (aHs)      mPtr = 1'b1;
      else if (mHs) mPtr = 1'b0;
    end
    mW = e.w;
    mC = e.c;
    mD = e.d;
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    chk("rf_w", 64'(rf_w), 64'(e.w));
    if (e.w || e.full) begin
      chk("rf_c", 64'(rf_c), 64'(e.c));
      chk("rf_dataC", rf_dataC, e.d);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; claim_valid = 1'b0;
    alu_addr = '0; mem_addr = '0; claim_addr = '0; chk_a = '0; chk_b = '0;
    alu_data = '0; mem_data = '0;
    @(negedge clk);

    // reset state, with requests present to show ready stays low
    alu_valid = 1'b1; mem_valid = 1'b1;
    cycle(); cycle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    rst_n = 1'b1;
    cycle();

    // ALU only
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'h1234;
    cycle();
    alu_valid = 1'b0;
    cycle(); cycle();

    // contention straight after reset: ALU first, then strict alternation
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 64'hAAAA_0003;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 64'hBBBB_0004;
    repeat (10) cycle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();

    // claim then retire register 7
    claim_valid = 1'b1; claim_addr = 5'd7; chk_a = 5'd7; chk_b = 5'd8;
    cycle();
    claim_valid = 1'b0;
    cycle();
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 64'hDEAD_BEEF_0000_0007;
    cycle();
    mem_valid = 1'b0;
    cycle(); cycle();

    // same-cycle set and clear of register 9
    chk_a = 5'd9; chk_b = 5'd7;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'h9999;
    cycle();
    alu_valid = 1'b0; claim_valid = 1'b1; claim_addr = 5'd9;
    cycle();
    claim_valid = 1'b0;
    cycle();
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 64'h0909;
    cycle();
    mem_valid = 1'b0;
    cycle(); cycle();

    // zero register: accepted, never written, never busy
    alu_valid = 1'b1; alu_addr = 5'd31; alu_data = 64'hFFFF;
    claim_valid = 1'b1; claim_addr = 5'd31; chk_a = 5'd31; chk_b = 5'd31;
    cycle();
    alu_valid = 1'b0; claim_valid = 1'b0;
    cycle(); cycle();

    // random traffic; a refused requester holds its request
    for (int i = 0; i < 80; i++) begin
      if (!(alu_valid && !expAluRdy)) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_addr  = 5'($urandom);
        alu_data  = {$urandom, $urandom};
      end
      if (!(mem_valid && !expMemRdy)) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_addr  = 5'($urandom);
        mem_data  = {$urandom, $urandom};
      end
      claim_valid = ($urandom_range(0, 3) == 0);
      claim_addr  = 5'($urandom);
      chk_a       = 5'($urandom);
      chk_b       = 5'($urandom);
      cycle();
    end
    alu_valid = 1'b0; mem_valid = 1'b0; claim_valid = 1'b0;
    cycle();

    // reset mid-operation: request in flight is dropped
    claim_valid = 1'b1; claim_addr = 5'd12; chk_a = 5'd12; chk_b = 5'd7;
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 64'h1212;
    cycle(1'b1);
    claim_valid = 1'b0; mem_valid = 1'b1; mem_addr = 5'd13;
    cycle(); cycle();
    rst_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
